// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// ALU opcodes, divider state encoding and an operand magnitude helper.
package hilo_mdu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ALUOP_W = 8;
  localparam int unsigned DIV_ITER = DATA_W;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 8'h20;
  localparam logic [ALUOP_W-1:0] ALUOP_MFHI  = 8'h10;
  localparam logic [ALUOP_W-1:0] ALUOP_MTHI  = 8'h11;
  localparam logic [ALUOP_W-1:0] ALUOP_MFLO  = 8'h12;
  localparam logic [ALUOP_W-1:0] ALUOP_MTLO  = 8'h13;
  localparam logic [ALUOP_W-1:0] ALUOP_MULT  = 8'h18;
  localparam logic [ALUOP_W-1:0] ALUOP_MULTU = 8'h19;
  localparam logic [ALUOP_W-1:0] ALUOP_DIV   = 8'h1A;
  localparam logic [ALUOP_W-1:0] ALUOP_DIVU  = 8'h1B;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // Magnitude of a signed operand; unsigned operands pass through untouched.
  function automatic logic [DATA_W-1:0] op_mag(input logic [DATA_W-1:0] x, input logic is_signed);
    return (is_signed && x[DATA_W-1]) ? DATA_W'(-x) : x;
  endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// E-stage operand/opcode bundle between the pipeline and the multiply/divide unit.
interface hilo_mdu_if;
  import hilo_mdu_pkg::*;

  logic [ALUOP_W-1:0] aluopE;
  logic [DATA_W-1:0]  srcaE;
  logic [DATA_W-1:0]  srcbE;
  logic               stall_inE;
  logic               cancelE;
  logic [DATA_W-1:0]  hilo_rdataE;
  logic               stall_divE;

  modport master (
    output aluopE, srcaE, srcbE, stall_inE, cancelE,
    input  hilo_rdataE, stall_divE
  );

  modport slave (
    input  aluopE, srcaE, srcbE, stall_inE, cancelE,
    output hilo_rdataE, stall_divE
  );
endinterface

// File: rtl/hilo_mdu_div_radix2.sv
// Iterative radix-2 restoring divider: magnitudes in, one quotient bit per
// cycle, sign correction applied on the outputs.
module div_radix2
  import hilo_mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  localparam int unsigned CNT_W = $clog2(DIV_ITER);

  mdu_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rem_q, quo_q, dvs_q;
  logic [DATA_W-1:0]  rem_d, quo_d;
  logic [DATA_W:0]    trial_c;
  logic               rem_neg_q, quo_neg_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial_c = {rem_q, quo_q[DATA_W-1]};
    rem_d   = trial_c[DATA_W-1:0];
    quo_d   = {quo_q[DATA_W-2:0], 1'b0};
    if (trial_c >= {1'b0, dvs_q}) begin
      rem_d    = DATA_W'(trial_c - {1'b0, dvs_q});
      quo_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
    end else if (abort_i) begin
      state_q <= MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE: if (start_i) begin
          state_q   <= MDU_BUSY;
          cnt_q     <= '0;
          rem_q     <= '0;
          quo_q     <= op_mag(dividend_i, signed_i);
          dvs_q     <= op_mag(divisor_i, signed_i);
          rem_neg_q <= signed_i & dividend_i[DATA_W-1];
          quo_neg_q <= signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
        end
        MDU_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_ITER - 1)) state_q <= MDU_DONE;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign busy_o      = (state_q == MDU_BUSY);
  assign done_o      = (state_q == MDU_DONE);
  assign quotient_o  = quo_neg_q ? DATA_W'(-quo_q) : quo_q;
  assign remainder_o = rem_neg_q ? DATA_W'(-rem_q) : rem_q;

endmodule

// File: rtl/hilo_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, single-cycle multiply,
// iterative divide with pipeline stall, MTHI/MTLO/MFHI/MFLO.
module hilo_mdu
  import hilo_mdu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  hilo_mdu_if.slave  bus
);

  logic [DATA_W-1:0]   hi_q, lo_q, hi_d, lo_d;
  logic [2*DATA_W-1:0] prod_s_c, prod_u_c;
  logic [DATA_W-1:0]   quo_c, rem_c;
  logic                div_busy, div_done;
  logic                is_div_c, div_start_c, div_abort_c, commit_c;

  assign prod_s_c = 64'($signed(bus.srcaE) * $signed(bus.srcbE));
  assign prod_u_c = 64'(bus.srcaE) * 64'(bus.srcbE);

  // Start only from idle; a zero divisor never starts, so HI/LO stay put.
  always_comb begin
    is_div_c    = (bus.aluopE == ALUOP_DIV) || (bus.aluopE == ALUOP_DIVU);
    div_start_c = rst && !div_busy && !div_done && is_div_c &&
                  (bus.srcbE != '0) && !bus.cancelE;
    commit_c    = !bus.stall_inE && !bus.cancelE;
    div_abort_c = bus.cancelE || (div_done && !bus.stall_inE);
  end

  div_radix2 u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start_c),
    .signed_i    (bus.aluopE == ALUOP_DIV),
    .dividend_i  (bus.srcaE),
    .divisor_i   (bus.srcbE),
    .abort_i     (div_abort_c),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (quo_c),
    .remainder_o (rem_c)
  );

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit_c) begin
      if (div_done) begin
        lo_d = quo_c;
        hi_d = rem_c;
      end else begin
        case (bus.aluopE)
          ALUOP_MULT:  {hi_d, lo_d} = prod_s_c;
          ALUOP_MULTU: {hi_d, lo_d} = prod_u_c;
          ALUOP_MTHI:  hi_d = bus.srcaE;
          ALUOP_MTLO:  lo_d = bus.srcaE;
          default:     ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.stall_divE  = div_start_c || (rst && div_busy && !bus.cancelE);
  assign bus.hilo_rdataE = (bus.aluopE == ALUOP_MFHI) ? hi_q :
                           (bus.aluopE == ALUOP_MFLO) ? lo_q : '0;

endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS core.
- Consumes the registered ALU opcode (aluopE) and forwarded operands produced for E.
- Owns the HI/LO architectural registers.
- Services MULT/MULTU (single cycle), DIV/DIVU (iterative, stalls pipeline), MTHI/MTLO and MFHI/MFLO.

Parameters:
- DIV_ITER, 32, number of radix-2 restoring divide iterations; fixed to data width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- aluopE  in  8  ALUOP_* code of instruction in E
- srcaE  in  32  rs operand (forwarded)
- srcbE  in  32  rt operand (forwarded)
- stall_inE  in  1  E held by any source other than this block
- cancelE  in  1  instruction in E is killed (exception/flush); abort and no HI/LO write
- hilo_rdataE  out  32  HI for MFHI, LO for MFLO, else 0
- stall_divE  out  1  hold F/D/E; divide in progress

Behaviour:
- Reset (rst=0, async): HI=0, LO=0, FSM=IDLE, quotient/remainder/counter=0, stall_divE=0.
- Commit rule: HI/LO update only on a rising edge where the instruction leaves E: stall_inE=0 and cancelE=0 (and, for DIV, state DONE).
- MULT: {HI,LO} <= signed 64-bit product.
- MULTU: {HI,LO} <= unsigned 64-bit product.
- MULT/MULTU are combinational within the E cycle, committed at end of E, with no stall.
- MTHI writes HI<=srcaE; MTLO writes LO<=srcaE; other register unchanged.
- MFHI/MFLO: hilo_rdataE combinational from current HI/LO. A write by the preceding instruction is already committed, so no forwarding is needed.
- DIV/DIVU FSM, states IDLE, BUSY, DONE:
  - IDLE, aluopE is DIV/DIVU, srcbE != 0, cancelE=0: stall_divE=1 combinationally. Latch |srca|, |srcb| (signed) or raw (unsigned), sign flags, counter=0. Go to BUSY.
  - BUSY: stall_divE=1. One restoring step per cycle, counter++. After iteration 32 go to DONE.
  - DONE: stall_divE=0. Sign fix: quotient negated if dividend/divisor signs differ; remainder takes dividend sign. Stay in DONE while stall_inE=1. When stall_inE=0: LO<=quotient, HI<=remainder, go to IDLE.
- Latency: stall_divE high for exactly 33 cycles (issue + 32 BUSY). Result committed at end of the first non-stalled DONE cycle.
- Divide by zero (srcbE=0): no iteration, no stall, HI/LO unchanged.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no trap).
- cancelE=1 in any state: next state IDLE, stall_divE=0 in that same cycle, no HI/LO write, partial results discarded.
- Mid-division reset: immediate IDLE, HI/LO=0.
- DIV is not restarted while in DONE/BUSY; a start is accepted only from IDLE.

Decomposition:
- ALUOP_* codes stay in the shared defines.vh.
- Add MDU_IDLE/MDU_BUSY/MDU_DONE state encodings there.
- One sub-module: div_radix2.
  - Inputs: start, signed_op, dividend, divisor, abort.
  - Outputs: busy, done, quotient, remainder.
  - Contains the iteration datapath and counter.
- hilo_mdu keeps HI/LO, the mult path, the commit logic and the stall generation.

Test Plan:
- MULT srca=0xFFFFFFFE (-2), srcb=3, stall_inE=0 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA; stall_divE never 1.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> stall_divE high 33 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 100/7 -> LO=14, HI=2.
- DIVU srcb=0 with HI=0x11, LO=0x22 -> no stall, HI/LO unchanged; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV started, cancelE pulsed at BUSY cycle 10 -> stall_divE drops same cycle, FSM IDLE, HI/LO unchanged; a fresh DIV next cycle completes correctly.
- DIVU 9/4 reaches DONE with stall_inE=1 for 3 cycles -> stall_divE=0, no restart, HI/LO written once (LO=2, HI=1) when stall_inE falls; MTHI 0xABCD then MFHI -> hilo_rdataE=0xABCD.
- rst driven low mid-BUSY -> immediately stall_divE=0, HI=LO=0; after release, MFLO returns 0.
